regfile_dump: RTL
=================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of registers walked (indices 0..NREGS-1).
REQ-002 SHALL have parameter DATA_W, default 32, register and stream data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a full register dump; sampled only in IDLE.
REQ-006 SHALL have port port_req  output  1  request ownership of the regfile debug read port.
REQ-007 SHALL have port port_gnt  input  1  core grants the read port (core holds writes stable).
REQ-008 SHALL have port rf_addr  output  5  register index driven to the regfile read address.
REQ-009 SHALL have port rf_rdata  input  DATA_W  combinational regfile read data for rf_addr.
REQ-010 SHALL have port out_valid  output  1  stream word valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts word.
REQ-012 SHALL have port out_data  output  DATA_W  captured register value.
REQ-013 SHALL have port out_index  output  5  register index of out_data.
REQ-014 SHALL have port out_last  output  1  high with the word for index NREGS-1.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on dump completion.

Function
REQ-017 SHALL implement states IDLE, REQ, READ, SEND, DONE.
REQ-018 IDLE: start=1 -> REQ, index counter cleared to 0; otherwise stay.
REQ-019 REQ: port_req=1; port_gnt=1 -> READ; otherwise stay.
REQ-020 READ: port_req=1, rf_addr=index; if port_gnt=1, capture rf_rdata into out_data, index into out_index, -> SEND; if port_gnt=0, stay in READ with no capture.
REQ-021 SEND: port_req=1, out_valid=1; out_data/out_index/out_last held stable until out_valid&&out_ready.
REQ-022 SEND handshake: on out_ready=1, if index==NREGS-1 -> DONE, else index+1 and -> READ.
REQ-023 DONE: port_req=0, done=1 for exactly one cycle, -> IDLE.
REQ-024 out_valid SHALL never deassert in SEND without an accepted transfer.
REQ-025 Index 0 SHALL be emitted with whatever rf_rdata returns (0 for x0); no index skipped.
REQ-026 Index counter SHALL not wrap: the transfer at NREGS-1 ends the dump.
REQ-027 start asserted while busy SHALL be ignored; no queuing.
REQ-028 start asserted in the DONE cycle SHALL be ignored; a new dump needs start in IDLE.
REQ-029 port_gnt dropping in SEND SHALL not affect the held word; the next READ waits for re-grant.
REQ-030 rf_addr SHALL equal the index counter in all states (0 in IDLE).
REQ-031 Latency (cycle 0 = start sampled, port_gnt and out_ready held 1): REQ in cycle 1, READ cycle 2, word k valid in cycle 3+2k, done in cycle 66 for NREGS=32.

Reset
REQ-032 reset=1 SHALL, at the next rising edge, force IDLE from any state, including mid-dump.
REQ-033 After reset: port_req=0, out_valid=0, out_last=0, busy=0, done=0, out_data=0, out_index=0, rf_addr=0, index counter=0.
REQ-034 reset SHALL take priority over start, port_gnt and out_ready in the same cycle.

Verification
REQ-035 Regfile preloaded x5=6, x9=0x1004, x10=10, others 0; start pulse, gnt=1, ready=1 -> 32 words, indices 0..31 in order, values match, out_last only on index 31, done in cycle 66.
REQ-036 port_gnt held 0 for 10 cycles after start -> port_req=1, out_valid=0 throughout; first word appears 2 cycles after gnt rises.
REQ-037 out_ready=0 for 5 cycles on index 9 -> out_valid stays 1, out_data=0x1004 stable; index 10 (value 10) follows after acceptance.
REQ-038 reset asserted while SEND holds index 5 -> next cycle IDLE, all outputs at reset values; later start dumps from index 0.
REQ-039 start pulsed during dump and during DONE -> no second dump; busy falls after DONE, done pulses once.
REQ-040 Regfile write to x3 (value 0xDEAD) before start, gnt=1 -> word index 3 reads 0xDEAD.

Source files
------------

// File: rtl/regfile_dump.sv
// Walks register indices 0..NREGS-1 over the core's debug read port and streams
// each captured value out through a valid/ready interface, one word per index.
module regfile_dump #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              port_req,
    input  logic              port_gnt,
    output logic [4:0]        rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        SEND,
        DONE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  index_d;
    logic [DATA_W-1:0] data_d;
    logic [IDX_W-1:0]  oidx_d;
    logic              last_d;
    logic              port_req_d;
    logic              out_valid_d;
    logic              busy_d;
    logic              done_d;

    // Next-state, capture and output decode; outputs follow the next state so
    // they are registered yet line up with the state they describe.
    always_comb begin
        state_d = state;
        index_d = index;
        data_d  = out_data;
        oidx_d  = out_index;
        last_d  = out_last;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    index_d = '0;
                end
            end
            REQ: begin
                if (port_gnt) state_d = READ;
            end
            READ: begin
                if (port_gnt) begin
                    data_d  = rf_rdata;
                    oidx_d  = index;
                    last_d  = (index == LAST_IDX);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (index == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        index_d = index + IDX_W'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        port_req_d  = (state_d == REQ) || (state_d == READ) || (state_d == SEND);
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            port_req  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            index     <= index_d;
            out_data  <= data_d;
            out_index <= oidx_d;
            out_last  <= last_d;
            port_req  <= port_req_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign rf_addr = index;

endmodule
